// File: rtl/stream_scoreboard.sv
// stream_scoreboard
//   In-order scoreboard for the parallel-to-serial path. Expected words are
//   queued in an internal FIFO and compared on the fly against actual words
//   from the serial side under a per-bit mask. Keeps running match/error/item
//   counts, captures the first error, raises sticky protocol flags, runs a
//   watchdog and gives a done/pass verdict.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start, num_items      arm a run in IDLE/DONE; item count latched on start
//   cmp_mask              1 = bit compared (static during a run)
//   exp_valid/data/ready  expected-word push side (ready only in RUN)
//   act_valid/data        actual-word beats, no backpressure
//   busy, done, pass      state RUN, state DONE, verdict valid while done
//   err_pulse             one-cycle pulse per mismatch or underflow
//   match_cnt, error_cnt, item_cnt       running counters
//   first_err_idx/exp/act/vld            first-error capture
//   overflow, underflow, timeout         sticky flags
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | after reset; waits for start, ignores both streams
// S_RUN  | FIFO accepts expected words, act beats are checked
// S_DONE | run finished (item count reached or watchdog); verdict held
`timescale 1ns/1ps
module stream_scoreboard #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_items,
   input  logic [DATA_W-1:0] cmp_mask,
   input  logic              exp_valid,
   input  logic [DATA_W-1:0] exp_data,
   output logic              exp_ready,
   input  logic              act_valid,
   input  logic [DATA_W-1:0] act_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [CNT_W-1:0]  error_cnt,
   output logic [CNT_W-1:0]  item_cnt,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_act,
   output logic              first_err_vld,
   output logic              overflow,
   output logic              underflow,
   output logic              timeout
);

   localparam int AW    = $clog2(DEPTH);
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit WD_EN = (TIMEOUT > 0);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [AW:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]         wr_ptr_d, rd_ptr_d;
   logic [CNT_W-1:0]    num_q;
   logic [CNT_W-1:0]    item_cnt_q, match_cnt_q, error_cnt_q;
   logic [CNT_W-1:0]    first_err_idx_q;
   logic [DATA_W-1:0]   first_err_exp_q, first_err_act_q;
   logic                first_err_vld_q;
   logic                overflow_q, underflow_q, timeout_q;
   logic                pass_q, err_pulse_q;
   logic [WD_W-1:0]     wdog_q;

   logic                run, empty, full;
   logic [DATA_W-1:0]   head;
   logic                beat, pop, push, ovf_ev, mismatch, err_ev;
   logic                wd_expire, items_done, pass_next;

   assign run   = (state_q == S_RUN);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign beat      = run && act_valid;
   assign pop       = beat && !empty;
   // A pop in the same cycle frees a slot, so a push against a full FIFO is
   // still taken even though exp_ready is low.
   assign push      = run && exp_valid && (!full || pop);
   assign ovf_ev    = run && exp_valid && full && !pop;
   assign mismatch  = |((act_data ^ head) & cmp_mask);
   assign err_ev    = beat && (empty || mismatch);
   assign wd_expire = WD_EN && run && !beat && (wdog_q == '0);
   assign items_done = run && (item_cnt_q == num_q);

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   // Verdict sampled from the state as it will stand after this cycle.
   assign pass_next = (error_cnt_q == '0) && !err_ev &&
                      !overflow_q && !ovf_ev &&
                      !timeout_q && !wd_expire &&
                      (wr_ptr_d == rd_ptr_d);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         num_q           <= '0;
         item_cnt_q      <= '0;
         match_cnt_q     <= '0;
         error_cnt_q     <= '0;
         first_err_idx_q <= '0;
         first_err_exp_q <= '0;
         first_err_act_q <= '0;
         first_err_vld_q <= 1'b0;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
         timeout_q       <= 1'b0;
         pass_q          <= 1'b0;
         err_pulse_q     <= 1'b0;
         wdog_q          <= '0;
      end else begin
         err_pulse_q <= err_ev;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  wr_ptr_q        <= '0;
                  rd_ptr_q        <= '0;
                  num_q           <= num_items;
                  item_cnt_q      <= '0;
                  match_cnt_q     <= '0;
                  error_cnt_q     <= '0;
                  first_err_idx_q <= '0;
                  first_err_exp_q <= '0;
                  first_err_act_q <= '0;
                  first_err_vld_q <= 1'b0;
                  overflow_q      <= 1'b0;
                  underflow_q     <= 1'b0;
                  timeout_q       <= 1'b0;
                  wdog_q          <= WD_LOAD;
                  // An empty run has nothing to check and passes at once.
                  if (num_items == '0) begin
                     state_q <= S_DONE;
                     pass_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     pass_q  <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               if (beat) begin
                  item_cnt_q <= item_cnt_q + CNT_W'(1);
                  wdog_q     <= WD_LOAD;
               end else if (WD_EN && wdog_q != '0) begin
                  wdog_q <= wdog_q - WD_W'(1);
               end
               if (pop && !mismatch) begin
                  match_cnt_q <= match_cnt_q + CNT_W'(1);
               end
               if (err_ev) begin
                  if (error_cnt_q != '1) begin
                     error_cnt_q <= error_cnt_q + CNT_W'(1);
                  end
                  if (!first_err_vld_q) begin
                     first_err_vld_q <= 1'b1;
                     first_err_idx_q <= item_cnt_q;
                     first_err_exp_q <= empty ? '0 : head;
                     first_err_act_q <= act_data;
                  end
               end
               if (ovf_ev) begin
                  overflow_q <= 1'b1;
               end
               if (beat && empty) begin
                  underflow_q <= 1'b1;
               end
               if (wd_expire) begin
                  timeout_q <= 1'b1;
               end
               if (items_done || wd_expire) begin
                  state_q <= S_DONE;
                  pass_q  <= pass_next;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign exp_ready     = run && !full;
   assign busy          = run;
   assign done          = (state_q == S_DONE);
   assign pass          = pass_q;
   assign err_pulse     = err_pulse_q;
   assign match_cnt     = match_cnt_q;
   assign error_cnt     = error_cnt_q;
   assign item_cnt      = item_cnt_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_exp = first_err_exp_q;
   assign first_err_act = first_err_act_q;
   assign first_err_vld = first_err_vld_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;
   assign timeout       = timeout_q;

endmodule

// File: tb/tb_stream_scoreboard.sv
`timescale 1ns/1ps
module tb_stream_scoreboard;

   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int CW  = 16;
   localparam int TO  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_items = '0;
   logic [DW-1:0] cmp_mask = 8'hFF;
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_data = '0;
   logic          exp_ready;
   logic          act_valid = 1'b0;
   logic [DW-1:0] act_data = '0;
   logic          busy, done, pass, err_pulse;
   logic [CW-1:0] match_cnt, error_cnt, item_cnt, first_err_idx;
   logic [DW-1:0] first_err_exp, first_err_act;
   logic          first_err_vld, overflow, underflow, timeout;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;

   stream_scoreboard #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_items(num_items),
      .cmp_mask(cmp_mask), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(exp_ready), .act_valid(act_valid), .act_data(act_data),
      .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .match_cnt(match_cnt), .error_cnt(error_cnt), .item_cnt(item_cnt),
      .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
      .first_err_act(first_err_act), .first_err_vld(first_err_vld),
      .overflow(overflow), .underflow(underflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      exp_valid = 1'b0;
      act_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic do_start(input logic [CW-1:0] n);
      start     = 1'b1;
      num_items = n;
      tick();
      start     = 1'b0;
      pulse_cnt = 0;
   endtask

   // 10-item stream, act stream trails exp stream by two cycles.
   task automatic run_stream(input int bad_idx, input logic [DW-1:0] bad_val,
                             input logic [DW-1:0] mask);
      cmp_mask = mask;
      do_start(CW'(10));
      for (int c = 0; c < 12; c++) begin
         exp_valid = (c < 10);
         exp_data  = DW'(c);
         act_valid = (c >= 2);
         act_data  = (c - 2 == bad_idx) ? bad_val : DW'(c - 2);
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      exp_valid = 1'b1;
      act_valid = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, pass, err_pulse, exp_ready, first_err_vld, overflow, underflow, timeout} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000000",
                  {busy, done, pass, err_pulse, exp_ready, first_err_vld, overflow, underflow, timeout});
      end
      checks++;
      if ({match_cnt, error_cnt, item_cnt, first_err_idx, first_err_exp, first_err_act} !== '0) begin
         errors++;
         $display("FAIL reset_counters: match=%0d err=%0d item=%0d idx=%0d expected all 0",
                  match_cnt, error_cnt, item_cnt, first_err_idx);
      end
      rst_n = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (item_cnt !== '0 || underflow !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores_act: item=%0d underflow=%b busy=%b expected 0 0 0",
                  item_cnt, underflow, busy);
      end
   endtask

   task automatic test_match();
      run_stream(-1, 8'h00, 8'hFF);
      checks++;
      if (item_cnt !== 16'd10 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL match_last_beat: item=%0d busy=%b done=%b expected 10 1 0",
                  item_cnt, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errors++;
         $display("FAIL match_verdict: done=%b pass=%b expected 1 1", done, pass);
      end
      checks++;
      if (match_cnt !== 16'd10 || error_cnt !== 16'd0 || pulse_cnt != 0) begin
         errors++;
         $display("FAIL match_counts: match=%0d err=%0d pulses=%0d expected 10 0 0",
                  match_cnt, error_cnt, pulse_cnt);
      end
   endtask

   task automatic test_mismatch();
      run_stream(3, 8'h13, 8'hFF);
      tick();
      checks++;
      if (error_cnt !== 16'd1 || match_cnt !== 16'd9 || pulse_cnt != 1) begin
         errors++;
         $display("FAIL mismatch_counts: err=%0d match=%0d pulses=%0d expected 1 9 1",
                  error_cnt, match_cnt, pulse_cnt);
      end
      checks++;
      if (first_err_vld !== 1'b1 || first_err_idx !== 16'd3 ||
          first_err_exp !== 8'h03 || first_err_act !== 8'h13) begin
         errors++;
         $display("FAIL mismatch_capture: vld=%b idx=%0d exp=%h act=%h expected 1 3 03 13",
                  first_err_vld, first_err_idx, first_err_exp, first_err_act);
      end
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_verdict: done=%b pass=%b expected 1 0", done, pass);
      end
      run_stream(3, 8'h13, 8'h0F);
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || error_cnt !== 16'd0 || match_cnt !== 16'd10) begin
         errors++;
         $display("FAIL masked_verdict: done=%b pass=%b err=%0d match=%0d expected 1 1 0 10",
                  done, pass, error_cnt, match_cnt);
      end
      cmp_mask = 8'hFF;
   endtask

   task automatic test_underflow();
      do_start(CW'(2));
      act_valid = 1'b1;
      act_data  = 8'h55;
      tick();
      act_valid = 1'b0;
      checks++;
      if (underflow !== 1'b1 || error_cnt !== 16'd1 || err_pulse !== 1'b1) begin
         errors++;
         $display("FAIL underflow_flag: uf=%b err=%0d pulse=%b expected 1 1 1",
                  underflow, error_cnt, err_pulse);
      end
      checks++;
      if (first_err_vld !== 1'b1 || first_err_idx !== 16'd0 ||
          first_err_exp !== 8'h00 || first_err_act !== 8'h55) begin
         errors++;
         $display("FAIL underflow_capture: vld=%b idx=%0d exp=%h act=%h expected 1 0 00 55",
                  first_err_vld, first_err_idx, first_err_exp, first_err_act);
      end
      exp_valid = 1'b1;
      exp_data  = 8'h77;
      tick();
      exp_valid = 1'b0;
      act_valid = 1'b1;
      act_data  = 8'h77;
      tick();
      act_valid = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || match_cnt !== 16'd1 || error_cnt !== 16'd1) begin
         errors++;
         $display("FAIL underflow_verdict: done=%b pass=%b match=%0d err=%0d expected 1 0 1 1",
                  done, pass, match_cnt, error_cnt);
      end
      // First push and first act in the same cycle: no bypass, so underflow.
      do_start(CW'(1));
      exp_valid = 1'b1;
      exp_data  = 8'hAA;
      act_valid = 1'b1;
      act_data  = 8'hAA;
      tick();
      idle_inputs();
      checks++;
      if (underflow !== 1'b1 || error_cnt !== 16'd1 || match_cnt !== 16'd0) begin
         errors++;
         $display("FAIL same_cycle_underflow: uf=%b err=%0d match=%0d expected 1 1 0",
                  underflow, error_cnt, match_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL leftover_verdict: done=%b pass=%b expected 1 0", done, pass);
      end
   endtask

   task automatic test_overflow();
      cmp_mask = 8'hFF;
      do_start(CW'(5));
      for (int i = 0; i < 4; i++) begin
         exp_valid = 1'b1;
         exp_data  = 8'h10 + DW'(i);
         tick();
      end
      exp_valid = 1'b0;
      checks++;
      if (exp_ready !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: ready=%b ovf=%b expected 0 0", exp_ready, overflow);
      end
      exp_valid = 1'b1;
      exp_data  = 8'h14;
      act_valid = 1'b1;
      act_data  = 8'h10;
      tick();
      act_valid = 1'b0;
      checks++;
      if (overflow !== 1'b0 || match_cnt !== 16'd1 || exp_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop: ovf=%b match=%0d ready=%b expected 0 1 0",
                  overflow, match_cnt, exp_ready);
      end
      exp_data = 8'h15;
      tick();
      exp_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flag: got %b expected 1", overflow);
      end
      for (int i = 1; i < 5; i++) begin
         act_valid = 1'b1;
         act_data  = 8'h10 + DW'(i);
         tick();
      end
      act_valid = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || match_cnt !== 16'd5 || error_cnt !== 16'd0) begin
         errors++;
         $display("FAIL overflow_verdict: done=%b pass=%b match=%0d err=%0d expected 1 0 5 0",
                  done, pass, match_cnt, error_cnt);
      end
   endtask

   task automatic test_timeout();
      do_start(CW'(4));
      exp_valid = 1'b1;
      exp_data  = 8'h01;
      tick();
      exp_data  = 8'h02;
      act_valid = 1'b1;
      act_data  = 8'h01;
      tick();
      exp_valid = 1'b0;
      act_data  = 8'h02;
      tick();
      act_valid = 1'b0;
      for (int i = 0; i < TO - 1; i++) tick();
      checks++;
      if (timeout !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: to=%b done=%b busy=%b expected 0 0 1",
                  timeout, done, busy);
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || match_cnt !== 16'd2) begin
         errors++;
         $display("FAIL timeout_expire: to=%b done=%b pass=%b match=%0d expected 1 1 0 2",
                  timeout, done, pass, match_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      do_start(CW'(5));
      exp_valid = 1'b1;
      exp_data  = 8'h33;
      tick();
      exp_valid = 1'b0;
      act_valid = 1'b1;
      act_data  = 8'h44;
      tick();
      act_data  = 8'h00;
      tick();
      act_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({busy, done, pass, err_pulse, exp_ready, first_err_vld, overflow, underflow, timeout} !== 9'b0 ||
          {match_cnt, error_cnt, item_cnt, first_err_idx, first_err_exp, first_err_act} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: flags=%b err=%0d item=%0d expected 0 0 0",
                  {busy, done, pass, err_pulse, exp_ready, first_err_vld, overflow, underflow, timeout},
                  error_cnt, item_cnt);
      end
      do_start(CW'(0));
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_items: done=%b pass=%b busy=%b expected 1 1 0", done, pass, busy);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errors++;
         $display("FAIL zero_items_hold: done=%b pass=%b expected 1 1", done, pass);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_underflow();
      test_overflow();
      test_timeout();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
